// File: rtl/mem_pkg.sv
// Shared LSU types: FSM states, response error codes and load size/extend helpers.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_TIMEOUT  = 2'd2
  } lsu_err_e;

  // Low address bits that must be zero for an access of 2^size bytes.
  function automatic logic [2:0] size_mask(input logic [1:0] size);
    logic [2:0] m;
    case (size)
      2'd0:    m = 3'b000;
      2'd1:    m = 3'b001;
      2'd2:    m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

  function automatic logic [63:0] size_extend(input logic [63:0] d,
                                              input logic [1:0]  size,
                                              input logic        uns);
    logic [63:0] r;
    case (size)
      2'd0:    r = uns ? {56'd0, d[7:0]}  : {{56{d[7]}},  d[7:0]};
      2'd1:    r = uns ? {48'd0, d[15:0]} : {{48{d[15]}}, d[15:0]};
      2'd2:    r = uns ? {32'd0, d[31:0]} : {{32{d[31]}}, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load alignment: shift read data down to the addressed byte, then truncate/extend.
module lsu_load_align
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [2:0]            i_byte_off,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [DATA_WIDTH-1:0] w_shifted;

  assign w_shifted = i_rdata >> {i_byte_off, 3'b000};
  assign o_data    = DATA_WIDTH'(size_extend(64'(w_shifted), i_size, i_unsigned));

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit between the pipeline and the dcache; one request in flight at a time.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned requests return error 1 instead of being aligned down.
module mem_lsu
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned WAIT_LIMIT = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wrn,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  req_virtual,
  input  logic                  req_kill,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [1:0]            resp_err,
  output logic [ADDR_WIDTH-1:0] in_addr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [1:0]            wlen,
  output logic                  dcache_enable,
  output logic                  wrn,
  output logic                  virtual_mode,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  dcache_valid,
  input  logic                  write_done
);

  localparam int unsigned CNT_W = $clog2(WAIT_LIMIT + 1);

  lsu_state_e            r_state, w_state_nxt;
  logic                  r_wrn, r_uns, r_virtual, r_kill_drain;
  logic [1:0]            r_size;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_resp_data;
  lsu_err_e              r_resp_err;
  logic [CNT_W-1:0]      r_wait;

  logic                  w_accept, w_done, w_timeout, w_trap;
  logic [2:0]            w_mask;
  logic [ADDR_WIDTH-1:0] w_addr_aligned;
  logic [DATA_WIDTH-1:0] w_load_data;

  assign w_mask         = size_mask(req_size);
  assign w_addr_aligned = {req_addr[ADDR_WIDTH-1:3], req_addr[2:0] & ~w_mask};
`ifdef LSU_MISALIGN_TRAP_EN
  assign w_trap = |(req_addr[2:0] & w_mask);
`else
  assign w_trap = 1'b0;
`endif

  assign w_accept  = (r_state == ST_IDLE) && req_valid && !req_kill;
  assign w_done    = ((r_state == ST_ISSUE) || (r_state == ST_DRAIN)) &&
                     (r_wrn ? write_done : dcache_valid);
  assign w_timeout = (r_state == ST_ISSUE) && !w_done &&
                     (r_wait == CNT_W'(WAIT_LIMIT - 1));

  lsu_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .i_rdata    (rdata),
    .i_byte_off (r_addr[2:0]),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .o_data     (w_load_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Kill or timeout never abandons an outstanding access: DRAIN waits for the cache first.
  always_comb begin
    w_state_nxt   = r_state;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    dcache_enable = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        req_ready = reset;
        if (w_accept) w_state_nxt = w_trap ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE: begin
        dcache_enable = 1'b1;
        if (w_done)                    w_state_nxt = req_kill ? ST_IDLE : ST_RESP;
        else if (req_kill || w_timeout) w_state_nxt = ST_DRAIN;
      end
      ST_RESP: begin
        resp_valid  = !req_kill;
        w_state_nxt = ST_IDLE;
      end
      ST_DRAIN: begin
        dcache_enable = 1'b1;
        if (w_done) w_state_nxt = (r_kill_drain || req_kill) ? ST_IDLE : ST_RESP;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrn        <= 1'b0;
      r_uns        <= 1'b0;
      r_virtual    <= 1'b0;
      r_kill_drain <= 1'b0;
      r_size       <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_resp_data  <= '0;
      r_resp_err   <= ERR_OK;
      r_wait       <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_wrn        <= req_wrn;
            r_uns        <= req_unsigned;
            r_virtual    <= req_virtual;
            r_size       <= req_size;
            r_addr       <= w_addr_aligned;
            r_wdata      <= req_wdata;
            r_kill_drain <= 1'b0;
            r_wait       <= '0;
            r_resp_data  <= '0;
            r_resp_err   <= w_trap ? ERR_MISALIGN : ERR_OK;
          end
        end
        ST_ISSUE: begin
          r_wait <= r_wait + 1'b1;
          if (w_done)         r_resp_data  <= r_wrn ? '0 : w_load_data;
          else if (req_kill)  r_kill_drain <= 1'b1;
          else if (w_timeout) r_resp_err   <= ERR_TIMEOUT;
        end
        ST_DRAIN: begin
          if (req_kill) r_kill_drain <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign resp_data    = r_resp_data;
  assign resp_err     = r_resp_err;
  assign in_addr      = r_addr;
  assign wdata        = r_wdata;
  assign wlen         = r_size;
  assign wrn          = r_wrn;
  assign virtual_mode = r_virtual;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu (WAIT_LIMIT=8); honours LSU_MISALIGN_TRAP_EN when defined.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_wrn, req_unsigned, req_virtual, req_kill;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic [1:0]  resp_err;
  logic [63:0] in_addr, wdata, rdata;
  logic [1:0]  wlen;
  logic        dcache_enable, wrn, virtual_mode, dcache_valid, write_done;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   en_cnt = 0;
  int   resp_cnt = 0;

  always #5 clk = ~clk;

  mem_lsu #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .WAIT_LIMIT(8)) dut (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wrn(req_wrn),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_virtual(req_virtual), .req_kill(req_kill),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .in_addr(in_addr), .wdata(wdata), .wlen(wlen), .dcache_enable(dcache_enable),
    .wrn(wrn), .virtual_mode(virtual_mode), .rdata(rdata),
    .dcache_valid(dcache_valid), .write_done(write_done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (dcache_enable) en_cnt++;
      if (resp_valid) begin
        resp_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got data 0x%h err %0d, expected no response", resp_data, resp_err);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("resp_data", resp_data, e.data);
          check("resp_err", {62'd0, resp_err}, {62'd0, e.err});
        end
      end
    end
  end

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, {63'd0, req_ready}, 64'd1);
  endtask

  task automatic send(input logic w, input logic [1:0] sz, input logic u,
                      input logic [63:0] a, input logic [63:0] d, input logic v);
    wait_ready("ready_before_req");
    req_valid = 1'b1; req_wrn = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = d; req_virtual = v;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic load_test(input string name, input logic [1:0] sz, input logic u,
                           input logic [63:0] a, input logic [63:0] rd, input int lat,
                           input logic [63:0] exp_data, input logic [1:0] exp_err,
                           input logic [63:0] exp_addr);
    exp_t e;
    e.data = exp_data;
    e.err  = exp_err;
    exp_q.push_back(e);
    en_cnt = 0;
    send(1'b0, sz, u, a, 64'h0, 1'b0);
    rdata = rd;
    @(negedge clk);
    check({name, "_in_addr"}, in_addr, exp_addr);
    check({name, "_wrn"}, {63'd0, wrn}, 64'd0);
    repeat (lat) @(negedge clk);
    dcache_valid = 1'b1;
    @(posedge clk); #1;
    dcache_valid = 1'b0;
    wait_ready({name, "_ready_after"});
    check({name, "_en_cycles"}, 64'(en_cnt), 64'(lat + 1));
  endtask

  initial begin
    int rc;
    rst_n = 1'b0; req_valid = 1'b0; req_wrn = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; req_virtual = 1'b0; req_kill = 1'b0;
    rdata = '0; dcache_valid = 1'b0; write_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {63'd0, req_ready}, 64'd0);
    check("rst_enable", {63'd0, dcache_enable}, 64'd0);
    check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_resp_err", {62'd0, resp_err}, 64'd0);
    rst_n = 1'b1;

    load_test("ld_b_signed", 2'd0, 1'b0, 64'h80000003, 64'h00000000_AB000000, 0,
              64'hFFFF_FFFF_FFFF_FFAB, 2'd0, 64'h80000003);
    load_test("ld_h_unsigned", 2'd1, 1'b1, 64'h80000006, 64'hBEEF_0000_0000_0000, 2,
              64'h0000_0000_0000_BEEF, 2'd0, 64'h80000006);
    load_test("ld_h_signed", 2'd1, 1'b0, 64'h80000006, 64'hBEEF_0000_0000_0000, 1,
              64'hFFFF_FFFF_FFFF_BEEF, 2'd0, 64'h80000006);
    load_test("ld_w_signed", 2'd2, 1'b0, 64'h80000004, 64'h80000001_00000000, 0,
              64'hFFFF_FFFF_8000_0001, 2'd0, 64'h80000004);
    load_test("ld_w_unsigned", 2'd2, 1'b1, 64'h80000004, 64'h80000001_00000000, 0,
              64'h0000_0000_8000_0001, 2'd0, 64'h80000004);
    load_test("ld_d", 2'd3, 1'b0, 64'h80000008, 64'h01234567_89ABCDEF, 3,
              64'h01234567_89ABCDEF, 2'd0, 64'h80000008);
    load_test("ld_b_pos", 2'd0, 1'b0, 64'h80000001, 64'h00000000_00007F00, 0,
              64'h0000_0000_0000_007F, 2'd0, 64'h80000001);
    load_test("ld_limit_edge", 2'd3, 1'b0, 64'h80000018, 64'hCAFEF00D_CAFEF00D, 7,
              64'hCAFEF00D_CAFEF00D, 2'd0, 64'h80000018);
    load_test("ld_timeout", 2'd3, 1'b0, 64'h80000040, 64'h55555555_AAAAAAAA, 8,
              64'h0, 2'd2, 64'h80000040);

    // Store: write_done held for three cycles must only complete once.
    begin
      exp_t e;
      e.data = 64'h0;
      e.err  = 2'd0;
      exp_q.push_back(e);
      en_cnt = 0;
      rc = resp_cnt;
      send(1'b1, 2'd3, 1'b0, 64'h80000010, 64'h11223344_55667788, 1'b1);
      write_done = 1'b1;
      @(negedge clk);
      check("st_wrn", {63'd0, wrn}, 64'd1);
      check("st_wdata", wdata, 64'h11223344_55667788);
      check("st_wlen", {62'd0, wlen}, 64'd3);
      check("st_in_addr", in_addr, 64'h80000010);
      check("st_virtual", {63'd0, virtual_mode}, 64'd1);
      @(posedge clk); #1;
      check("st_ready_in_resp", {63'd0, req_ready}, 64'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      write_done = 1'b0;
      wait_ready("st_ready_after");
      check("st_en_cycles", 64'(en_cnt), 64'd1);
      check("st_resp_count", 64'(resp_cnt - rc), 64'd1);
    end

`ifdef LSU_MISALIGN_TRAP_EN
    begin
      exp_t e;
      e.data = 64'h0;
      e.err  = 2'd1;
      exp_q.push_back(e);
      en_cnt = 0;
      send(1'b0, 2'd2, 1'b0, 64'h80000002, 64'h0, 1'b0);
      @(negedge clk);
      check("mis_enable", {63'd0, dcache_enable}, 64'd0);
      wait_ready("mis_ready_after");
      check("mis_en_cycles", 64'(en_cnt), 64'd0);
    end
`else
    load_test("ld_misaligned", 2'd2, 1'b0, 64'h80000002, 64'h00000000_DEADBEEF, 0,
              64'hFFFF_FFFF_DEAD_BEEF, 2'd0, 64'h80000000);
`endif

    // Kill while IDLE with a valid request: nothing accepted.
    wait_ready("kill_idle_ready");
    req_valid = 1'b1; req_kill = 1'b1; req_wrn = 1'b0; req_addr = 64'h80000100;
    @(posedge clk); #1;
    req_valid = 1'b0; req_kill = 1'b0;
    @(negedge clk);
    check("kill_idle_enable", {63'd0, dcache_enable}, 64'd0);
    check("kill_idle_ready_kept", {63'd0, req_ready}, 64'd1);

    // Kill during ISSUE: access drains for 20 cycles, no response.
    en_cnt = 0;
    rc = resp_cnt;
    send(1'b0, 2'd3, 1'b0, 64'h80000020, 64'h0, 1'b0);
    rdata = 64'h12345678_9ABCDEF0;
    req_kill = 1'b1;
    @(posedge clk); #1;
    req_kill = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    dcache_valid = 1'b1;
    @(posedge clk); #1;
    dcache_valid = 1'b0;
    @(negedge clk);
    check("kill_issue_ready", {63'd0, req_ready}, 64'd1);
    check("kill_issue_en_cycles", 64'(en_cnt), 64'd21);
    check("kill_issue_no_resp", 64'(resp_cnt - rc), 64'd0);

    // Kill during RESP suppresses resp_valid.
    rc = resp_cnt;
    send(1'b0, 2'd3, 1'b0, 64'h80000028, 64'h0, 1'b0);
    dcache_valid = 1'b1;
    @(posedge clk); #1;
    dcache_valid = 1'b0;
    req_kill = 1'b1;
    @(negedge clk);
    check("kill_resp_valid", {63'd0, resp_valid}, 64'd0);
    @(posedge clk); #1;
    req_kill = 1'b0;
    wait_ready("kill_resp_ready");
    check("kill_resp_no_resp", 64'(resp_cnt - rc), 64'd0);

    // Asynchronous reset in the middle of ISSUE.
    rc = resp_cnt;
    send(1'b1, 2'd3, 1'b0, 64'h80000080, 64'hFEEDFACE_0BADF00D, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_enable", {63'd0, dcache_enable}, 64'd0);
    check("arst_req_ready", {63'd0, req_ready}, 64'd0);
    check("arst_wrn", {63'd0, wrn}, 64'd0);
    check("arst_in_addr", in_addr, 64'h0);
    check("arst_wdata", wdata, 64'h0);
    check("arst_virtual", {63'd0, virtual_mode}, 64'd0);
    check("arst_resp_err", {62'd0, resp_err}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    write_done = 1'b1;
    @(posedge clk); #1;
    write_done = 1'b0;
    wait_ready("arst_ready_after");
    repeat (3) @(posedge clk);
    #1;
    check("arst_no_resp", 64'(resp_cnt - rc), 64'd0);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
